// File: rtl/axis_frame_tx.sv
// axis_frame_tx: FIFO-buffered AXI4-Stream frame source (tuser=SOF, tlast=EOL).
// Optional macro AXIS_TX_ROWGAP_EN adds ROW_GAP idle cycles after each non-final row.
module axis_frame_tx #(
  parameter int AXISIN_DATA_WIDTH = 24,
  parameter int SRC_IMG_WIDTH     = 960,
  parameter int SRC_IMG_HEIGHT    = 540,
  parameter int FIFO_DEPTH        = 16,
  parameter int ROW_GAP           = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           frame_done,
  input  logic                           pix_valid,
  input  logic [AXISIN_DATA_WIDTH-1:0]   pix_data,
  output logic                           pix_ready,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [AXISIN_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXISIN_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [AXISIN_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser
);

  localparam int DW   = AXISIN_DATA_WIDTH;
  localparam int NPIX = SRC_IMG_WIDTH * SRC_IMG_HEIGHT;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int XW   = (SRC_IMG_WIDTH > 1) ? $clog2(SRC_IMG_WIDTH) : 1;
  localparam int YW   = (SRC_IMG_HEIGHT > 1) ? $clog2(SRC_IMG_HEIGHT) : 1;
  localparam int IW   = $clog2(NPIX + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [XW-1:0] X_LAST   = XW'(SRC_IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(SRC_IMG_HEIGHT - 1);
  localparam logic [IW-1:0] IN_TOTAL = IW'(NPIX);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP,
    DONE
  } state_t;

  state_t          state;
  logic [XW-1:0]   x_cnt;
  logic [YW-1:0]   y_cnt;
  logic [IW-1:0]   in_cnt;

  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

`ifdef AXIS_TX_ROWGAP_EN
  localparam int GW = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(ROW_GAP - 1);
  logic [GW-1:0]   gap_cnt;
`endif

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign pix_ready  = busy & ~full & (in_cnt < IN_TOTAL);
  assign push       = pix_valid & pix_ready;

  assign m_axis_tvalid = (state == STREAM) & ~empty;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;
  assign m_axis_tkeep  = '1;
  assign m_axis_tstrb  = '1;
  // Framing is gated by tvalid so idle/reset outputs stay low.
  assign m_axis_tlast  = m_axis_tvalid & (x_cnt == X_LAST);
  assign m_axis_tuser  = m_axis_tvalid & (x_cnt == '0) & (y_cnt == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pix_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      x_cnt  <= '0;
      y_cnt  <= '0;
      in_cnt <= '0;
`ifdef AXIS_TX_ROWGAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      if (push) in_cnt <= in_cnt + 1'b1;
      case (state)
        IDLE: begin
          x_cnt  <= '0;
          y_cnt  <= '0;
          in_cnt <= '0;
          if (start) state <= STREAM;
        end
        STREAM: begin
          if (pop) begin
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              if (y_cnt == Y_LAST) begin
                y_cnt <= '0;
                state <= DONE;
              end else begin
                y_cnt <= y_cnt + 1'b1;
`ifdef AXIS_TX_ROWGAP_EN
                gap_cnt <= '0;
                state   <= GAP;
`endif
              end
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end
        end
`ifdef AXIS_TX_ROWGAP_EN
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= STREAM;
          else gap_cnt <= gap_cnt + 1'b1;
        end
`endif
        DONE: begin
          x_cnt  <= '0;
          y_cnt  <= '0;
          in_cnt <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
